// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the N-master memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin pick: search starts one past the last winner.
module rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    localparam int IDW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDW-1:0]         ptr,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IDW-1:0]         gnt_idx,
    output logic                   gnt_any
);

    int j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            j = (int'(ptr) + i) % NUM_MASTERS;
            if (!gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-master to single-memory arbiter: round-robin grant, one transaction in
// flight, memory-ready handshake with optional timeout error response.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT,
    localparam int IDW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_req_valid,
    input  logic [NUM_MASTERS-1:0]            m_req_write,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_req_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_req_wdata,
    output logic [NUM_MASTERS-1:0]            m_req_ready,
    output logic [NUM_MASTERS-1:0]            m_resp_valid,
    output logic [DATA_WIDTH-1:0]             m_resp_data,
    output logic                              m_resp_error,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_data_out,
    output logic                              mem_read_enable,
    output logic                              mem_write_enable,
    input  logic [DATA_WIDTH-1:0]             mem_data_in,
    input  logic                              mem_ready,
    output logic                              busy,
    output logic [IDW-1:0]                    grant_id
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [IDW-1:0]          grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    rd_en_q, rd_en_d;
    logic                    wr_en_q, wr_en_d;
    logic [NUM_MASTERS-1:0]  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                    resp_err_q, resp_err_d;

    logic [NUM_MASTERS-1:0]  win_onehot;
    logic [IDW-1:0]          win_idx;
    logic                    win_any;

    rr_arbiter #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_rr (
        .req     (m_req_valid),
        .ptr     (ptr_q),
        .gnt     (win_onehot),
        .gnt_idx (win_idx),
        .gnt_any (win_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        cnt_d        = cnt_q;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        resp_valid_d = '0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    ptr_d   = win_idx;
                    grant_d = win_idx;
                    addr_d  = m_req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = m_req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    write_d = m_req_write[win_idx];
                    // Strobes are registered here so they are high exactly during ISSUE.
                    rd_en_d = ~m_req_write[win_idx];
                    wr_en_d = m_req_write[win_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    resp_valid_d[grant_q] = 1'b1;
                    resp_data_d           = write_q ? '0 : mem_data_in;
                    state_d               = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    resp_valid_d[grant_q] = 1'b1;
                    resp_err_d            = 1'b1;
                    state_d               = RESP;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= IDW'(NUM_MASTERS - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            cnt_q        <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            cnt_q        <= cnt_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign m_req_ready      = (state_q == IDLE) ? win_onehot : '0;
    assign m_resp_valid     = resp_valid_q;
    assign m_resp_data      = resp_data_q;
    assign m_resp_error     = resp_err_q;
    assign mem_addr         = addr_q;
    assign mem_data_out     = wdata_q;
    assign mem_read_enable  = rd_en_q;
    assign mem_write_enable = wr_en_q;
    assign busy             = (state_q != IDLE);
    assign grant_id         = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: instance A (2 masters, timeout 4), instance B (4 masters, no timeout).
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]  req_valid_a, req_write_a, req_ready_a, resp_valid_a;
    logic [31:0] req_addr_a;
    logic [63:0] req_wdata_a;
    logic [31:0] resp_data_a, mem_dout_a, mem_din_a;
    logic        resp_err_a, mem_re_a, mem_we_a, mem_ready_a, busy_a;
    logic [15:0] mem_addr_a;
    logic [0:0]  grant_a;

    logic [3:0]   req_valid_b, req_write_b, req_ready_b, resp_valid_b;
    logic [63:0]  req_addr_b;
    logic [127:0] req_wdata_b;
    logic [31:0]  resp_data_b, mem_dout_b, mem_din_b;
    logic         resp_err_b, mem_re_b, mem_we_b, mem_ready_b, busy_b;
    logic [15:0]  mem_addr_b;
    logic [1:0]   grant_b;

    int checks   = 0;
    int failures = 0;
    int wcnt [2];
    int em;

    mem_arbiter #(.NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT(4)) u_a (
        .clk(clk), .reset(reset),
        .m_req_valid(req_valid_a), .m_req_write(req_write_a),
        .m_req_addr(req_addr_a), .m_req_wdata(req_wdata_a),
        .m_req_ready(req_ready_a), .m_resp_valid(resp_valid_a),
        .m_resp_data(resp_data_a), .m_resp_error(resp_err_a),
        .mem_addr(mem_addr_a), .mem_data_out(mem_dout_a),
        .mem_read_enable(mem_re_a), .mem_write_enable(mem_we_a),
        .mem_data_in(mem_din_a), .mem_ready(mem_ready_a),
        .busy(busy_a), .grant_id(grant_a)
    );

    mem_arbiter #(.NUM_MASTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT(0)) u_b (
        .clk(clk), .reset(reset),
        .m_req_valid(req_valid_b), .m_req_write(req_write_b),
        .m_req_addr(req_addr_b), .m_req_wdata(req_wdata_b),
        .m_req_ready(req_ready_b), .m_resp_valid(resp_valid_b),
        .m_resp_data(resp_data_b), .m_resp_error(resp_err_b),
        .mem_addr(mem_addr_b), .mem_data_out(mem_dout_b),
        .mem_read_enable(mem_re_b), .mem_write_enable(mem_we_b),
        .mem_data_in(mem_din_b), .mem_ready(mem_ready_b),
        .busy(busy_b), .grant_id(grant_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int m, input logic v, input logic w,
                         input logic [15:0] ad, input logic [31:0] d);
        req_valid_a[m]          = v;
        req_write_a[m]          = w;
        req_addr_a[m*16 +: 16]  = ad;
        req_wdata_a[m*32 +: 32] = d;
    endtask

    task automatic set_b(input int m, input logic v, input logic w,
                         input logic [15:0] ad, input logic [31:0] d);
        req_valid_b[m]          = v;
        req_write_b[m]          = w;
        req_addr_b[m*16 +: 16]  = ad;
        req_wdata_b[m*32 +: 32] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        req_valid_a = '0; req_write_a = '0; req_addr_a = '0; req_wdata_a = '0;
        mem_din_a   = '0; mem_ready_a = 1'b0;
        req_valid_b = '0; req_write_b = '0; req_addr_b = '0; req_wdata_b = '0;
        mem_din_b   = '0; mem_ready_b = 1'b0;
        repeat (3) tick();

        chk("rst_busy_a", busy_a, 0);
        chk("rst_resp_valid_a", resp_valid_a, 0);
        chk("rst_enables_a", {mem_re_a, mem_we_a}, 0);
        chk("rst_mem_addr_a", mem_addr_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_grant_b", grant_b, 0);
        reset = 1'b1;
        tick();

        // Both masters stream three writes each; mem_ready held high throughout.
        wcnt[0] = 0; wcnt[1] = 0;
        for (int m = 0; m < 2; m++)
            set_a(m, 1'b1, 1'b1, 16'h0100 * (m + 1), 32'hD0D0_0000 | (m << 8));
        mem_ready_a = 1'b1;
        mem_din_a   = 32'h5555_5555;
        for (int t = 0; t < 6; t++) begin
            em = t % 2;
            #1;
            for (int k = 0; k < 20 && req_ready_a == 0; k++) tick();
            chk("t2_ready", req_ready_a, 2'b01 << em);
            tick();
            chk("t2_we", {mem_we_a, mem_re_a}, 2'b10);
            chk("t2_addr", mem_addr_a, 16'h0100 * (em + 1) + wcnt[em]);
            chk("t2_data", mem_dout_a, 32'hD0D0_0000 | (em << 8) | wcnt[em]);
            wcnt[em]++;
            set_a(em, wcnt[em] < 3, 1'b1, 16'h0100 * (em + 1) + wcnt[em],
                  32'hD0D0_0000 | (em << 8) | wcnt[em]);
            tick();
            chk("t2_we_single", mem_we_a, 0);
            tick();
            chk("t2_resp", {resp_valid_a, resp_err_a}, {2'b01 << em, 1'b0});
            chk("t2_resp_data", resp_data_a, 0);
            tick();
        end
        mem_ready_a = 1'b0;

        // Master 0 read, ready two cycles after the strobe.
        set_a(0, 1'b1, 1'b0, 16'h0010, 32'h0);
        #1;
        chk("t1_ready", req_ready_a, 2'b01);
        tick();
        set_a(0, 1'b0, 1'b0, 16'h0, 32'h0);
        chk("t1_re", {mem_re_a, mem_we_a}, 2'b10);
        chk("t1_addr", mem_addr_a, 16'h0010);
        chk("t1_busy", busy_a, 1);
        tick();
        chk("t1_re_off", mem_re_a, 0);
        tick();
        mem_ready_a = 1'b1;
        mem_din_a   = 32'hDEAD_BEEF;
        tick();
        mem_ready_a = 1'b0;
        chk("t1_resp_valid", resp_valid_a, 2'b01);
        chk("t1_resp_data", resp_data_a, 32'hDEAD_BEEF);
        chk("t1_resp_err", resp_err_a, 0);
        tick();
        chk("t1_after", {resp_valid_a, resp_data_a, busy_a}, 0);

        // Master 1 read, memory never ready: error after 4 WAIT cycles.
        mem_din_a = 32'h1234_5678;
        set_a(1, 1'b1, 1'b0, 16'h0ABC, 32'h0);
        #1;
        chk("t3_ready", req_ready_a, 2'b10);
        tick();
        set_a(1, 1'b0, 1'b0, 16'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_wait_noresp", {resp_valid_a, busy_a}, 3'b001);
        end
        tick();
        chk("t3_resp_valid", resp_valid_a, 2'b10);
        chk("t3_resp_err", resp_err_a, 1);
        chk("t3_resp_data", resp_data_a, 0);
        tick();

        // Ready arrives on the terminal count cycle: ready wins.
        set_a(0, 1'b1, 1'b0, 16'h0044, 32'h0);
        #1;
        chk("t4_ready", req_ready_a, 2'b01);
        tick();
        set_a(0, 1'b0, 1'b0, 16'h0, 32'h0);
        repeat (4) tick();
        mem_ready_a = 1'b1;
        mem_din_a   = 32'hCAFE_F00D;
        tick();
        mem_ready_a = 1'b0;
        chk("t4_resp_valid", resp_valid_a, 2'b01);
        chk("t4_resp_err", resp_err_a, 0);
        chk("t4_resp_data", resp_data_a, 32'hCAFE_F00D);
        tick();

        // Reset while in WAIT drops the transaction and rewinds the pointer.
        set_a(0, 1'b1, 1'b0, 16'h0055, 32'h0);
        tick();
        set_a(0, 1'b0, 1'b0, 16'h0, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("t5_busy", busy_a, 0);
        chk("t5_noresp", resp_valid_a, 0);
        chk("t5_re", mem_re_a, 0);
        reset = 1'b1;
        tick();
        chk("t5_noresp_after", {resp_valid_a, busy_a}, 0);
        set_a(0, 1'b1, 1'b0, 16'h0066, 32'h0);
        set_a(1, 1'b1, 1'b0, 16'h0077, 32'h0);
        #1;
        chk("t5_first_grant", req_ready_a, 2'b01);
        tick();
        req_valid_a = '0;
        chk("t5_grant_id", grant_a, 0);
        chk("t5_addr", mem_addr_a, 16'h0066);
        mem_ready_a = 1'b1;
        mem_din_a   = 32'h0000_0066;
        tick();
        tick();
        mem_ready_a = 1'b0;
        chk("t5_resp", resp_valid_a, 2'b01);
        tick();

        // 4 masters: master 2 alone, ready pulses in IDLE/ISSUE ignored, no timeout.
        set_b(2, 1'b1, 1'b0, 16'h0222, 32'h0);
        mem_ready_b = 1'b1;
        #1;
        chk("t6_ready_m2", req_ready_b, 4'b0100);
        tick();
        set_b(2, 1'b0, 1'b0, 16'h0, 32'h0);
        chk("t6_grant_m2", grant_b, 2);
        chk("t6_re", mem_re_b, 1);
        chk("t6_addr", mem_addr_b, 16'h0222);
        tick();
        mem_ready_b = 1'b0;
        chk("t6_not_early", {resp_valid_b, busy_b}, 5'b00001);
        repeat (20) tick();
        chk("t6_busy_hold", {resp_valid_b, busy_b}, 5'b00001);
        mem_din_b   = 32'h2222_2222;
        mem_ready_b = 1'b1;
        tick();
        mem_ready_b = 1'b0;
        chk("t6_resp_valid", resp_valid_b, 4'b0100);
        chk("t6_resp_data", resp_data_b, 32'h2222_2222);
        chk("t6_resp_err", resp_err_b, 0);
        tick();
        set_b(1, 1'b1, 1'b1, 16'h0111, 32'h1111_AAAA);
        #1;
        chk("t6_ready_m1", req_ready_b, 4'b0010);
        tick();
        set_b(1, 1'b0, 1'b0, 16'h0, 32'h0);
        chk("t6_grant_m1", grant_b, 1);
        chk("t6_we", {mem_we_b, mem_re_b}, 2'b10);
        chk("t6_wdata", mem_dout_b, 32'h1111_AAAA);
        tick();
        mem_ready_b = 1'b1;
        tick();
        mem_ready_b = 1'b0;
        chk("t6_resp_m1", resp_valid_b, 4'b0010);
        chk("t6_resp_m1_data", resp_data_b, 0);
        tick();
        chk("t6_idle", busy_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-master to single-memory arbiter.
- Sits between up to NUM_MASTERS cpu instances and one memory instance. Replaces the fixed point-to-point cpu-to-memory wiring.
- Round-robin grant, one outstanding transaction at a time, memory-ready handshake, optional timeout with error response.

Parameters:
NUM_MASTERS, 2, number of requesting masters (>=1)
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 16, address bus width
TIMEOUT, 15, max WAIT cycles before error response; 0 disables timeout
IDW (localparam), max(1,$clog2(NUM_MASTERS)), grant index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
m_req_valid  in  NUM_MASTERS  per-master request valid; held until accepted
m_req_write  in  NUM_MASTERS  1=write, 0=read
m_req_addr  in  NUM_MASTERS*ADDR_WIDTH  flattened; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_req_wdata  in  NUM_MASTERS*DATA_WIDTH  flattened write data
m_req_ready  out  NUM_MASTERS  one-hot accept strobe
m_resp_valid  out  NUM_MASTERS  one-hot 1-cycle response strobe
m_resp_data  out  DATA_WIDTH  read data, shared, qualified by m_resp_valid
m_resp_error  out  1  timeout flag, qualified by m_resp_valid
mem_addr  out  ADDR_WIDTH  to memory addr_in
mem_data_out  out  DATA_WIDTH  to memory data_in
mem_read_enable  out  1  1-cycle read strobe
mem_write_enable  out  1  1-cycle write strobe
mem_data_in  in  DATA_WIDTH  from memory data_out
mem_ready  in  1  from memory ready
busy  out  1  high in any state except IDLE
grant_id  out  IDW  index of the master currently owning the bus

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, rr pointer=NUM_MASTERS-1 (master 0 wins first), all outputs 0, timeout counter 0. Any in-flight transaction is dropped and produces no response.
- FSM states and transitions:
  - IDLE: if any m_req_valid, pick winner by searching from pointer+1 mod N. m_req_ready[winner]=1 (combinational, IDLE only). Latch addr, wdata, write. grant_id<=winner, pointer<=winner. Go to ISSUE. If no m_req_valid, stay in IDLE.
  - ISSUE: exactly one of mem_read_enable/mem_write_enable=1 for this cycle. mem_addr/mem_data_out = latched values. Clear counter. Go to WAIT.
  - WAIT: enables 0; mem_addr/mem_data_out held stable.
    - mem_ready=1: capture mem_data_in (reads) or 0 (writes), error=0, go to RESP.
    - Else counter+1; when counter==TIMEOUT-1 with no ready: data=0, error=1, go to RESP.
    - TIMEOUT=0: wait indefinitely.
  - RESP: m_resp_valid[grant_id]=1, m_resp_data/m_resp_error driven, all registered. Go to IDLE.
- Latency: accept at cycle T; ISSUE T+1; earliest WAIT-with-ready T+2; resp_valid T+3. Back-to-back accept at T+4 at the earliest.
- mem_ready is ignored outside WAIT.
- If mem_ready and the timeout terminal count occur in the same cycle, ready wins (no error).
- m_req_valid dropped before accept: no transaction. After accept, the master's inputs are don't-care.
- Outside RESP, m_resp_data and m_resp_error are 0.
- NUM_MASTERS=1: arbitration degenerates to a pass-through and grant_id stays 0.
- No address or data arithmetic. The counter width is $clog2(TIMEOUT+1) and never wraps.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP) and a default-timeout constant.
- Sub-module rr_arbiter: combinational one-hot winner from request vector + pointer, plus binary index output. Parametrised by NUM_MASTERS.
- mem_arbiter holds the FSM, latches, timeout counter and response registers.

Test Plan:
1. N=2, master0 read addr 0x0010, memory returns 0xDEADBEEF with ready 2 cycles after strobe -> m_req_ready[0] at T, mem_read_enable at T+1 only, m_resp_valid=2'b01 with data 0xDEADBEEF at T+4, error 0.
2. Both masters valid continuously, each doing 3 writes -> grant order 0,1,0,1,0,1; each write produces exactly one mem_write_enable pulse carrying the correct addr/data.
3. TIMEOUT=4, memory never asserts ready -> resp_valid after 4 WAIT cycles with error=1 and data=0x00000000. TIMEOUT=0 variant: busy stays high indefinitely.
4. mem_ready and timeout terminal count coincide -> error=0, data = mem_data_in.
5. reset asserted low in WAIT -> next cycle: IDLE, busy=0, no m_resp_valid. After release, master 0 is granted first.
6. N=4, only master 2 requests, then master 1 -> grant_id 2 then 1; mem_ready pulses in IDLE/ISSUE are ignored and do not end the transaction early.
